// File: rtl/zet_mem_io_resp.sv
// rtl/zet_mem_io_resp.sv - strobe/ack bus responder: word RAM, I/O register bank, wait states, split odd-word accesses
module zet_mem_io_resp #(
  parameter int AW          = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [19:0] adr_i,
  input  logic [15:0] dat_i,
  output logic [15:0] dat_o,
  input  logic        we_i,
  input  logic        mio_i,
  input  logic        byte_i,
  input  logic        stb_i,
  output logic        ack_o
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACC1, S_ACC2, S_ACK} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t        state, state_nx;
  logic [15:0]   adr_q;
  logic [15:0]   dat_q;
  logic          we_q, mio_q, byte_q;
  logic [3:0]    wait_cnt;
  logic [15:0]   ram [0:(1<<AW)-1];
  logic [15:0]   io_reg [0:3];

  logic          split;
  logic [AW-1:0] word_idx, ram_addr;
  logic [15:0]   ram_rd, io_word, src, rd_nx, ram_wd;
  logic [1:0]    ram_be, io_idx;
  logic          io_hit;
  logic          unused_adr;

  // Address bits above the I/O port range never select anything (aliasing).
  assign unused_adr = ^adr_i[19:16];

  assign split    = mio_q & ~byte_q & adr_q[0];
  assign word_idx = adr_q[AW:1];
  assign ram_addr = (state == S_ACC2) ? word_idx + AW'(1) : word_idx;
  assign ram_rd   = ram[ram_addr];
  assign io_hit   = (adr_q[15:3] == 13'd0);
  assign io_idx   = adr_q[2:1];
  assign io_word  = io_hit ? io_reg[io_idx] : 16'hFFFF;
  assign src      = mio_q ? ram_rd : io_word;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state: wait states first, then one or two access cycles, then ack.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (stb_i) state_nx = (WAIT_STATES > 0) ? S_WAIT : S_ACC1;
      S_WAIT: if (wait_cnt == 4'd1) state_nx = S_ACC1;
      S_ACC1: state_nx = split ? S_ACC2 : S_ACK;
      S_ACC2: state_nx = S_ACK;
      S_ACK:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Capture the request once in IDLE; count down the wait states.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adr_q    <= 16'h0000;
      dat_q    <= 16'h0000;
      we_q     <= 1'b0;
      mio_q    <= 1'b0;
      byte_q   <= 1'b0;
      wait_cnt <= 4'd0;
    end else if (state == S_IDLE && stb_i) begin
      adr_q    <= adr_i[15:0];
      dat_q    <= dat_i;
      we_q     <= we_i;
      mio_q    <= mio_i;
      byte_q   <= byte_i;
      wait_cnt <= WS;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // RAM lane enables: byte and odd-word halves each touch a single lane.
  always_comb begin
    ram_be = 2'b00;
    ram_wd = dat_q;
    if (mio_q && we_q) begin
      if (state == S_ACC1) begin
        if (byte_q) begin
          ram_be = adr_q[0] ? 2'b10 : 2'b01;
          ram_wd = {dat_q[7:0], dat_q[7:0]};
        end else if (adr_q[0]) begin
          ram_be = 2'b10;
          ram_wd = {dat_q[7:0], 8'h00};
        end else begin
          ram_be = 2'b11;
        end
      end else if (state == S_ACC2) begin
        ram_be = 2'b01;
        ram_wd = {8'h00, dat_q[15:8]};
      end
    end
  end

  // Single-port RAM write; contents deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (ram_be[0]) ram[ram_addr][7:0]  <= ram_wd[7:0];
    if (ram_be[1]) ram[ram_addr][15:8] <= ram_wd[15:8];
  end

  // Read-data assembly: lane select for bytes, low/high halves for split words.
  always_comb begin
    rd_nx = dat_o;
    if (!we_q) begin
      if (state == S_ACC1) begin
        if (byte_q)     rd_nx = {8'h00, adr_q[0] ? src[15:8] : src[7:0]};
        else if (split) rd_nx = {dat_o[15:8], src[15:8]};
        else            rd_nx = src;
      end else if (state == S_ACC2) begin
        rd_nx = {src[7:0], dat_o[7:0]};
      end
    end
  end

  // Output registers: read data held between reads, ack one cycle after ACK state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_o <= 16'h0000;
      ack_o <= 1'b0;
    end else begin
      dat_o <= rd_nx;
      ack_o <= (state == S_ACK);
    end
  end

  // I/O register bank writes; out-of-range ports are silently dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) io_reg[i] <= 16'h0000;
    end else if (state == S_ACC1 && !mio_q && we_q && io_hit) begin
      if (!byte_q)       io_reg[io_idx]       <= dat_q;
      else if (adr_q[0]) io_reg[io_idx][15:8] <= dat_q[7:0];
      else               io_reg[io_idx][7:0]  <= dat_q[7:0];
    end
  end

endmodule

// File: tb/tb_zet_mem_io_resp.sv
// tb/tb_zet_mem_io_resp.sv - self-checking bench for zet_mem_io_resp
module tb_zet_mem_io_resp;

  logic        clk, rst;
  logic [19:0] adr  [2];
  logic [15:0] dat  [2];
  logic [15:0] dato [2];
  logic        we_s [2], mio_s [2], byt_s [2], stb [2], ack [2];

  int n_cmp = 0;
  int n_err = 0;
  int ws [2] = '{0, 3};

  logic [7:0]  mem_m [2][32768];
  logic [7:0]  io_m  [2][8];
  logic [15:0] last_rd [2];

  zet_mem_io_resp #(.AW(14), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr[0]), .dat_i(dat[0]), .dat_o(dato[0]),
    .we_i(we_s[0]), .mio_i(mio_s[0]), .byte_i(byt_s[0]), .stb_i(stb[0]), .ack_o(ack[0]));

  zet_mem_io_resp #(.AW(14), .WAIT_STATES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr[1]), .dat_i(dat[1]), .dat_o(dato[1]),
    .we_i(we_s[1]), .mio_i(mio_s[1]), .byte_i(byt_s[1]), .stb_i(stb[1]), .ack_o(ack[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    bit          mio;
    bit          byt;
    logic [19:0] a;
    logic [15:0] d;
    logic [15:0] xdat;
    int          xlat;
  } vec_t;

  vec_t tbl [29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-addressed reference: memory is a flat byte array, I/O an 8-byte file.
  task automatic model_apply(input int d, input bit we, input bit mio, input bit byt,
                             input logic [19:0] a, input logic [15:0] dt,
                             output logic [15:0] rd, output int lat);
    int b, p;
    rd  = 16'h0000;
    lat = ws[d] + 2;
    if (mio) begin
      b = int'(a[14:0]);
      if (!byt && a[0]) lat++;
      if (we) begin
        mem_m[d][b] = dt[7:0];
        if (!byt) mem_m[d][(b + 1) % 32768] = dt[15:8];
      end else begin
        rd = byt ? {8'h00, mem_m[d][b]} : {mem_m[d][(b + 1) % 32768], mem_m[d][b]};
      end
    end else begin
      p = int'(a[15:0]);
      if (p < 8) begin
        if (byt) begin
          if (we) io_m[d][p] = dt[7:0];
          else    rd = {8'h00, io_m[d][p]};
        end else begin
          b = p & 6;
          if (we) begin
            io_m[d][b]     = dt[7:0];
            io_m[d][b + 1] = dt[15:8];
          end else begin
            rd = {io_m[d][b + 1], io_m[d][b]};
          end
        end
      end else begin
        rd = byt ? 16'h00FF : 16'hFFFF;
      end
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) io_m[d][i] = 8'h00;
      last_rd[d] = 16'h0000;
    end
  endtask

  // Entered #1 after a clock edge with the DUT idle; returns #1 after the ack edge.
  task automatic run_txn(input int d, input bit we, input bit mio, input bit byt,
                         input logic [19:0] a, input logic [15:0] dt,
                         output logic [15:0] rd, output int lat);
    adr[d] = a; dat[d] = dt; we_s[d] = we; mio_s[d] = mio; byt_s[d] = byt; stb[d] = 1'b1;
    @(posedge clk); #1;
    stb[d]   = 1'b0;
    adr[d]   = 20'($urandom);
    dat[d]   = 16'($urandom);
    we_s[d]  = 1'($urandom);
    mio_s[d] = 1'($urandom);
    byt_s[d] = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ack[d]) begin
        lat = k;
        break;
      end
    end
    rd = dato[d];
  endtask

  task automatic txn_check(input int d, input bit we, input bit mio, input bit byt,
                           input logic [19:0] a, input logic [15:0] dt,
                           input bit use_tbl, input logic [15:0] tdat, input int tlat,
                           input string name);
    logic [15:0] exp, got;
    int xl, lat;
    model_apply(d, we, mio, byt, a, dt, exp, xl);
    if (use_tbl) begin
      exp = tdat;
      xl  = tlat;
    end
    run_txn(d, we, mio, byt, a, dt, got, lat);
    chk({name, "_lat"}, lat, xl);
    if (lat >= 0) begin
      @(posedge clk); #1;
      chk({name, "_ackw"}, ack[d], 0);
      if (!we) begin
        chk({name, "_rd"}, got, exp);
        last_rd[d] = exp;
      end else begin
        chk({name, "_hold"}, got, last_rd[d]);
      end
    end
  endtask

  // Reset the system n_after edges past the capture edge of a write.
  task automatic abort_write(input int d, input logic [19:0] a, input logic [15:0] dt,
                             input int n_after, input string name);
    adr[d] = a; dat[d] = dt; we_s[d] = 1'b1; mio_s[d] = 1'b1; byt_s[d] = 1'b0; stb[d] = 1'b1;
    @(posedge clk); #1;
    stb[d] = 1'b0;
    repeat (n_after) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk({name, "_ack0"}, ack[0], 0);
    chk({name, "_ack1"}, ack[1], 0);
    chk({name, "_dat0"}, dato[0], 0);
    chk({name, "_dat1"}, dato[1], 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      chk({name, "_noack"}, ack[d], 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [19:0] a;
    logic [15:0] rx;
    int xl;

    tbl[0]  = '{1, 1, 0, 20'h00100, 16'h1234, 16'h0000, 2};
    tbl[1]  = '{0, 1, 0, 20'h00100, 16'h0000, 16'h1234, 2};
    tbl[2]  = '{1, 1, 1, 20'h00101, 16'h00AB, 16'h0000, 2};
    tbl[3]  = '{0, 1, 1, 20'h00100, 16'h0000, 16'h0034, 2};
    tbl[4]  = '{0, 1, 1, 20'h00101, 16'h0000, 16'h00AB, 2};
    tbl[5]  = '{0, 1, 0, 20'h00100, 16'h0000, 16'hAB34, 2};
    tbl[6]  = '{0, 1, 0, 20'h80100, 16'h0000, 16'hAB34, 2};
    tbl[7]  = '{1, 1, 0, 20'h00200, 16'h1111, 16'h0000, 2};
    tbl[8]  = '{1, 1, 0, 20'h00202, 16'h2222, 16'h0000, 2};
    tbl[9]  = '{1, 1, 0, 20'h00201, 16'hBEEF, 16'h0000, 3};
    tbl[10] = '{0, 1, 0, 20'h00200, 16'h0000, 16'hEF11, 2};
    tbl[11] = '{0, 1, 0, 20'h00202, 16'h0000, 16'h22BE, 2};
    tbl[12] = '{0, 1, 0, 20'h00201, 16'h0000, 16'hBEEF, 3};
    tbl[13] = '{1, 0, 0, 20'h00004, 16'h5A5A, 16'h0000, 2};
    tbl[14] = '{0, 0, 0, 20'h00004, 16'h0000, 16'h5A5A, 2};
    tbl[15] = '{0, 0, 0, 20'h00010, 16'h0000, 16'hFFFF, 2};
    tbl[16] = '{1, 0, 0, 20'h00010, 16'h1234, 16'h0000, 2};
    tbl[17] = '{0, 0, 0, 20'h00004, 16'h0000, 16'h5A5A, 2};
    tbl[18] = '{0, 0, 1, 20'h00005, 16'h0000, 16'h005A, 2};
    tbl[19] = '{0, 0, 1, 20'h00010, 16'h0000, 16'h00FF, 2};
    tbl[20] = '{0, 0, 0, 20'h00005, 16'h0000, 16'h5A5A, 2};
    tbl[21] = '{1, 1, 0, 20'h07FFE, 16'h5566, 16'h0000, 2};
    tbl[22] = '{1, 1, 0, 20'h00000, 16'h7788, 16'h0000, 2};
    tbl[23] = '{1, 1, 0, 20'h07FFF, 16'hA1B2, 16'h0000, 3};
    tbl[24] = '{0, 1, 0, 20'h07FFE, 16'h0000, 16'hB266, 2};
    tbl[25] = '{0, 1, 0, 20'h00000, 16'h0000, 16'h77A1, 2};
    tbl[26] = '{0, 1, 0, 20'h07FFF, 16'h0000, 16'hA1B2, 3};
    tbl[27] = '{1, 0, 1, 20'hF0006, 16'h00C3, 16'h0000, 2};
    tbl[28] = '{0, 0, 0, 20'h00006, 16'h0000, 16'h00C3, 2};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      adr[d] = '0; dat[d] = '0; we_s[d] = 0; mio_s[d] = 0; byt_s[d] = 0; stb[d] = 0;
    end
    model_reset();
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ack", ack[d], 0);
      chk("reset_dat", dato[d], 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 29; i++)
      txn_check(0, tbl[i].we, tbl[i].mio, tbl[i].byt, tbl[i].a, tbl[i].d,
                1'b1, tbl[i].xdat, tbl[i].xlat, $sformatf("vec%0d", i));

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 34; i++)
        txn_check(d, 1, 1, 0, 20'h01000 + 20'(2 * i), 16'($urandom), 0, 0, 0, "prefill");

    // Three back-to-back reads with stb held high on the wait-state instance.
    model_apply(1, 0, 1, 0, 20'h01004, 16'h0000, rx, xl);
    adr[1] = 20'h01004; we_s[1] = 0; mio_s[1] = 1; byt_s[1] = 0; stb[1] = 1;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk); #1;
      if (k >= 2) begin
        chk($sformatf("held_ack_k%0d", k), ack[1], (k == 6 || k == 12 || k == 18));
        if (ack[1]) chk("held_rd", dato[1], rx);
      end
      if (k == 18) stb[1] = 0;
    end
    last_rd[1] = rx;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 60; i++) begin
        bit we, mio, byt;
        we  = 1'($urandom);
        mio = ($urandom_range(0, 3) != 0);
        byt = 1'($urandom);
        if (mio) begin
          a = 20'h01000 + 20'($urandom_range(0, 63));
          a[19:15] = 5'($urandom);
        end else begin
          a = 20'($urandom_range(0, 15));
          a[19:16] = 4'($urandom);
        end
        txn_check(d, we, mio, byt, a, 16'($urandom), 0, 0, 0, $sformatf("rnd%0d_%0d", d, i));
      end

    abort_write(1, 20'h01010, 16'hDEAD, 1, "abort_wait");
    txn_check(1, 0, 1, 0, 20'h01010, 16'h0000, 0, 0, 0, "after_abort");
    txn_check(0, 0, 0, 0, 20'h00004, 16'h0000, 0, 0, 0, "io_cleared");

    abort_write(1, 20'h01021, 16'hC0DE, 4, "abort_acc2");
    mem_m[1][16'h1021] = 8'hDE;
    txn_check(1, 0, 1, 0, 20'h01020, 16'h0000, 0, 0, 0, "half_lo");
    txn_check(1, 0, 1, 0, 20'h01022, 16'h0000, 0, 0, 0, "half_hi");
    txn_check(1, 1, 1, 0, 20'h07FFF, 16'h3C4D, 0, 0, 0, "wrap_wr");
    txn_check(1, 0, 1, 0, 20'h07FFF, 16'h0000, 0, 0, 0, "wrap_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
